// File: rtl/spi_master_cfg.sv
// spi_master_cfg: SPI master with independent TX/RX frame lengths, all four CPOL/CPHA modes and a PC/BUSY/DONE handshake.
// Optional macro SPI_MASTER_LSB_FIRST_EN adds an LSB_FIRST input that selects LSB-first bit order.
module spi_master_cfg #(
  parameter int frame_length_MOSI = 8,
  parameter int frame_length_MISO = 8,
  parameter int clk_prescaler     = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_n,
  input  logic                         PC,
  input  logic                         CPOL,
  input  logic                         CPHA,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic                         LSB_FIRST,
`endif
  input  logic [frame_length_MOSI-1:0] DATA_out,
  input  logic                         MISO,
  output logic                         SCLK,
  output logic                         MOSI,
  output logic                         SS_n,
  output logic                         BUSY,
  output logic                         DONE,
  output logic [frame_length_MISO-1:0] DATA_in
);
  // state | meaning
  // IDLE  | SS_n high, SCLK follows CPOL, waiting for a PC rising edge
  // SETUP | SS_n low, first MOSI bit presented for one prescale period
  // SHIFT | 2N SCLK edges, one at the start of each prescale period
  // HOLD  | SCLK at CPOL, SS_n released on its final cycle

  localparam int LM = frame_length_MOSI;
  localparam int LS = frame_length_MISO;
  localparam int N  = (LM > LS) ? LM : LS;
  localparam int EW = $clog2(2*N + 1);
  localparam int PW = (clk_prescaler > 1) ? $clog2(clk_prescaler) : 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*N);
  localparam logic [PW-1:0] PRE_LOAD  = PW'(clk_prescaler - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state, state_nxt;

  logic [PW-1:0] cnt;
  logic [EW-1:0] edge_cnt;
  logic          sclk_q, pc_q, done_q, cpha_q;
  logic [N-1:0]  tx_q, load_word;
  logic [LS-1:0] rx_q, data_in_q;
  logic          lsb_q, lsb_load;
  logic          start, tc, last_edge, do_edge, sample, advance;

`ifdef SPI_MASTER_LSB_FIRST_EN
  always_ff @(posedge clk_in) begin
    if (!rst_n)     lsb_q <= 1'b0;
    else if (start) lsb_q <= LSB_FIRST;
  end
  assign lsb_load = LSB_FIRST;
`else
  assign lsb_q    = 1'b0;
  assign lsb_load = 1'b0;
`endif

  assign start     = (state == IDLE) && PC && !pc_q;
  assign tc        = (cnt == '0);
  assign last_edge = (edge_cnt == LAST_EDGE);
  assign do_edge   = tc && ((state == SETUP) || ((state == SHIFT) && !last_edge));
  // edge_cnt even means the upcoming edge is odd, i.e. a leading edge
  assign sample    = ~edge_cnt[0] ^ cpha_q;
  assign advance   = !sample && (cpha_q ? (edge_cnt != '0) : (edge_cnt != LAST_EDGE - 1'b1));

  // Frame bit k sits at tx_q[N-1-k]; pad bits beyond the MOSI length stay zero
  always_comb begin
    load_word = '0;
    for (int k = 0; k < LM; k++)
      load_word[N-1-k] = lsb_load ? DATA_out[k] : DATA_out[LM-1-k];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   if (tc) state_nxt = SHIFT;
      SHIFT:   if (tc && last_edge) state_nxt = HOLD;
      HOLD:    if (tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY = 1'b1;
    SS_n = 1'b0;
    MOSI = tx_q[N-1];
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        SS_n = 1'b1;
        MOSI = 1'b0;
      end
      HOLD:    SS_n = tc;
      default: ;
    endcase
  end

  assign SCLK    = sclk_q;
  assign DONE    = done_q;
  assign DATA_in = data_in_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      pc_q      <= 1'b1;
      cnt       <= '0;
      edge_cnt  <= '0;
      sclk_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_in_q <= '0;
      done_q    <= 1'b0;
      cpha_q    <= 1'b0;
    end else begin
      pc_q   <= PC;
      done_q <= (state == HOLD) && tc;
      if (state == IDLE) begin
        sclk_q <= CPOL;
        if (start) begin
          cnt      <= PRE_LOAD;
          edge_cnt <= '0;
          cpha_q   <= CPHA;
          tx_q     <= load_word;
          rx_q     <= '0;
        end
      end else begin
        cnt <= tc ? PRE_LOAD : cnt - 1'b1;
        if (do_edge) begin
          sclk_q   <= ~sclk_q;
          edge_cnt <= edge_cnt + 1'b1;
          if (sample)
            rx_q <= lsb_q ? ((rx_q >> 1) | (LS'(MISO) << (LS-1))) : ((rx_q << 1) | LS'(MISO));
          if (advance)
            tx_q <= tx_q << 1;
        end
        if ((state == HOLD) && tc)
          data_in_q <= rx_q;
      end
    end
  end

endmodule
